wb_periph_mux: RTL and testbench
================================

# wb_periph_mux

Single-master, multi-slave Wishbone classic interconnect that sits directly downstream of the OBI-to-Wishbone bridge. It decodes the bridge's address and routes each transfer to one of NSLV peripheral slaves, such as the pin-mux matrix or the I2C target. It returns that slave's read data and acknowledge upstream. Accesses outside the peripheral window, or optionally to stalled slaves, are answered with an error response, so the bridge can never hang.

## Interface

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NSLV, 4, number of downstream slaves; power of two, 2..16
- SEL_LSB, 8, lowest address bit of the slave index field
- BASE, 'h0, required value of wbs_addr_i[ADDR_W-1 : SEL_LSB+IDX_W]; IDX_W = $clog2(NSLV)
- TIMEOUT, 255, maximum ACCESS cycles before error; valid range 1..65535
- ERR_DATA, 32'hDEAD_BEEF, read data returned with an error

Ports:
- clk_i  in  1  single clock for the whole block
- rst_i  in  1  reset; synchronous, active-high
- wbs_addr_i  in  ADDR_W  upstream address
- wbs_wdata_i  in  DATA_W  upstream write data
- wbs_wr_en_i  in  1  upstream write enable
- wbs_byte_en_i  in  DATA_W/8  upstream byte enables
- wbs_stb_i  in  1  upstream strobe
- wbs_cyc_i  in  1  upstream cycle
- wbs_ack_o  out  1  upstream acknowledge, one-cycle pulse
- wbs_err_o  out  1  error flag, valid only while wbs_ack_o=1
- wbs_rdata_o  out  DATA_W  upstream read data
- wbm_addr_o  out  ADDR_W  latched address, common to all slaves
- wbm_wdata_o  out  DATA_W  latched write data, common to all slaves
- wbm_wr_en_o  out  1  latched write enable
- wbm_byte_en_o  out  DATA_W/8  latched byte enables
- wbm_stb_o  out  NSLV  one-hot per-slave strobe
- wbm_cyc_o  out  NSLV  one-hot per-slave cycle
- wbm_ack_i  in  NSLV  per-slave acknowledge
- wbm_rdata_i  in  NSLV*DATA_W  per-slave read data; slave i occupies bits [i*DATA_W +: DATA_W]

## Operation

- FSM has three states: IDLE, ACCESS, RESP.
- IDLE, when wbs_cyc_i & wbs_stb_i:
  - Latch the address, write data, write enable and byte enables into the wbm_* outputs.
  - Latch idx = wbs_addr_i[SEL_LSB +: IDX_W].
  - If the upper address field equals BASE, go to ACCESS. Otherwise go to RESP with err=1 and rdata=ERR_DATA.
- ACCESS:
  - wbm_stb_o[idx] = wbm_cyc_o[idx] = 1; all other bits 0.
  - When wbm_ack_i[idx]=1: capture wbm_rdata_i slice idx, set err=0, go to RESP.
  - Acks from non-selected slaves are ignored.
- RESP:
  - wbs_ack_o=1 for exactly one cycle; wbs_err_o per the captured err; wbs_rdata_o holds the captured data.
  - All wbm_stb_o/wbm_cyc_o bits are 0.
  - Next state is IDLE.
- Write transfers still return the captured rdata (the slave's bus value); the bridge ignores it.
- wbs_rdata_o holds its value until the next RESP.
- wbm_wr_en_o and wbm_byte_en_o are cleared to 0 on entry to RESP.
- If wbs_cyc_i falls during ACCESS (master abort), drop the slave strobe/cycle and go to IDLE without asserting wbs_ack_o.

## Timing

- Reset values: state IDLE; every output 0, including wbs_rdata_o and all wbm_* buses.
- rst_i asserted mid-ACCESS: wbm_stb_o/wbm_cyc_o are 0 after that edge. No ack is issued.
- Latency: request sampled at edge N gives slave strobe in cycle N+1.
  - A zero-wait slave acks in cycle N+1, so wbs_ack_o is high in cycle N+2.
  - Decode miss: wbs_ack_o is high in cycle N+1.
- Back-to-back: a new request is accepted in the IDLE cycle immediately after RESP. Throughput is at most one transfer per 3 cycles.
- A request is accepted only in IDLE; wbs_stb_i in ACCESS or RESP is not re-sampled.

## Configuration

- Macro: WB_PERIPH_MUX_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to ACCESS and increments every ACCESS cycle.
  - When the count reaches TIMEOUT-1 with no ack, the next state is RESP with err=1 and rdata=ERR_DATA; the slave strobe drops.
  - An ack in the same cycle as expiry wins: data is taken, err=0.
- Undefined: no counter exists; ACCESS waits indefinitely. Errors come from decode misses only.

## Structure

- Package wb_periph_pkg holds:
  - the state enum typedef (wb_mux_state_t);
  - the IDX_W computation function;
  - the ERR_DATA default constant.
- Sub-module wb_periph_timeout holds the counter and the expiry compare. It is instantiated only under WB_PERIPH_MUX_TIMEOUT_EN.

## Test plan

- Read from slave 2 (addr 'h0000_0200, slave acks after 3 wait cycles with 'hA5A5_0002) -> wbm_stb_o='b0100 for 4 cycles; one wbs_ack_o pulse, rdata='hA5A5_0002, err=0.
- Write 'h1234_5678 with byte_en 'b0011 to addr 'h0000_0100, zero-wait slave 1 -> wbm_* fields match, wr_en=1; ack 2 cycles after the request is sampled.
- Access addr 'h0001_0000 (outside BASE) -> no wbm_stb_o bit set; ack next cycle with err=1, rdata='hDEAD_BEEF.
- Macro defined, TIMEOUT=8, slave 3 never acks -> strobe high for exactly 8 cycles, then ack with err=1, rdata='hDEAD_BEEF. A second variant acks in the 8th cycle -> err=0.
- Stray wbm_ack_i[0] during an access to slave 1, then rst_i pulsed mid-ACCESS -> stray ack ignored; all outputs 0 after reset; no wbs_ack_o.
- Three back-to-back reads to slaves 0, 1, 3 -> each accepted in the IDLE cycle after RESP; rdata is correct and ordered.

Source files
------------

// File: rtl/wb_periph_pkg.sv
// Shared types and constants for the Wishbone peripheral interconnect.
// Holds the transfer FSM state type, the slave-index width helper and the
// default read data returned alongside an error response.
package wb_periph_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } wb_mux_state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Number of address bits needed to pick one of nslv slaves (at least 1).
  function automatic int unsigned idx_width(input int unsigned nslv);
    return (nslv > 1) ? $clog2(nslv) : 1;
  endfunction

endpackage

// File: rtl/wb_periph_timeout.sv
// Access watchdog for wb_periph_mux: counts cycles spent waiting on a slave
// and flags expiry once TIMEOUT cycles have elapsed without an acknowledge.
// Only instantiated when WB_PERIPH_MUX_TIMEOUT_EN is defined.
module wb_periph_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_run,
  output logic o_expired
);

  logic [15:0] r_count;

  // Count ACCESS cycles; the count sits at zero whenever no access is
  // running, so every new access starts from a cleared counter.
  always_ff @(posedge clk_i) begin
    if (rst_i || !i_run) begin
      r_count <= 16'd0;
    end else begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_expired = i_run && (r_count == 16'(TIMEOUT - 1));

endmodule

// File: rtl/wb_periph_mux.sv
// Single-master, multi-slave Wishbone classic interconnect.
// Decodes the upstream address into a one-hot slave select, forwards the
// latched transfer to that slave and returns its data/ack upstream.  Requests
// outside the peripheral window complete at once with an error response.
// Optional feature: define WB_PERIPH_MUX_TIMEOUT_EN to bound the time spent
// waiting on a slave; expiry completes the transfer with an error.
module wb_periph_mux
  import wb_periph_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          NSLV     = 4,
  parameter int unsigned          SEL_LSB  = 8,
  parameter logic [ADDR_W-1:0]    BASE     = '0,
  parameter int unsigned          TIMEOUT  = 255,
  parameter logic [DATA_W-1:0]    ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDR_W-1:0]        wbs_addr_i,
  input  logic [DATA_W-1:0]        wbs_wdata_i,
  input  logic                     wbs_wr_en_i,
  input  logic [DATA_W/8-1:0]      wbs_byte_en_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  output logic                     wbs_ack_o,
  output logic                     wbs_err_o,
  output logic [DATA_W-1:0]        wbs_rdata_o,
  output logic [ADDR_W-1:0]        wbm_addr_o,
  output logic [DATA_W-1:0]        wbm_wdata_o,
  output logic                     wbm_wr_en_o,
  output logic [DATA_W/8-1:0]      wbm_byte_en_o,
  output logic [NSLV-1:0]          wbm_stb_o,
  output logic [NSLV-1:0]          wbm_cyc_o,
  input  logic [NSLV-1:0]          wbm_ack_i,
  input  logic [NSLV*DATA_W-1:0]   wbm_rdata_i
);

  localparam int unsigned IDX_W  = idx_width(NSLV);
  localparam int unsigned UP_LSB = SEL_LSB + IDX_W;
  localparam int unsigned UP_W   = ADDR_W - UP_LSB;

  wb_mux_state_t r_state;
  wb_mux_state_t w_next;

  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_wr_en;
  logic [DATA_W/8-1:0] r_byte_en;
  logic [IDX_W-1:0]    r_idx;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_req;
  logic                w_hit;
  logic                w_sel_ack;
  logic [DATA_W-1:0]   w_sel_rdata;
  logic [NSLV-1:0]     w_onehot;
  logic                w_access;
  logic                w_expired;

  assign w_req       = wbs_cyc_i & wbs_stb_i;
  assign w_hit       = (wbs_addr_i[ADDR_W-1:UP_LSB] == BASE[UP_W-1:0]);
  assign w_sel_ack   = wbm_ack_i[r_idx];
  assign w_sel_rdata = wbm_rdata_i[r_idx*DATA_W +: DATA_W];
  assign w_onehot    = NSLV'(1) << r_idx;
  assign w_access    = (r_state == ST_ACCESS);

`ifdef WB_PERIPH_MUX_TIMEOUT_EN
  wb_periph_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_run     (w_access),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; a master abort takes priority over a slave ack so
  // that an abandoned cycle never produces an upstream acknowledge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_next = w_hit ? ST_ACCESS : ST_RESP;
        end
      end
      ST_ACCESS: begin
        if (!wbs_cyc_i) begin
          w_next = ST_IDLE;
        end else if (w_sel_ack || w_expired) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Transfer datapath: latch the request in IDLE, capture the response on the
  // way into RESP, and drop the write qualifiers once the transfer completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wr_en   <= 1'b0;
      r_byte_en <= '0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (r_state == ST_IDLE && w_req) begin
        r_addr    <= wbs_addr_i;
        r_wdata   <= wbs_wdata_i;
        r_wr_en   <= wbs_wr_en_i;
        r_byte_en <= wbs_byte_en_i;
        r_idx     <= wbs_addr_i[SEL_LSB +: IDX_W];
        if (!w_hit) begin
          r_err   <= 1'b1;
          r_rdata <= ERR_DATA;
        end
      end
      if (w_access && w_next == ST_RESP) begin
        if (w_sel_ack) begin
          r_err   <= 1'b0;
          r_rdata <= w_sel_rdata;
        end else begin
          r_err   <= 1'b1;
          r_rdata <= ERR_DATA;
        end
      end
      if (w_next == ST_RESP) begin
        r_wr_en   <= 1'b0;
        r_byte_en <= '0;
      end
    end
  end

  assign wbs_ack_o     = (r_state == ST_RESP);
  assign wbs_err_o     = wbs_ack_o & r_err;
  assign wbs_rdata_o   = r_rdata;
  assign wbm_addr_o    = r_addr;
  assign wbm_wdata_o   = r_wdata;
  assign wbm_wr_en_o   = r_wr_en;
  assign wbm_byte_en_o = r_byte_en;
  assign wbm_stb_o     = w_access ? w_onehot : '0;
  assign wbm_cyc_o     = w_access ? w_onehot : '0;

endmodule

// File: tb/tb_wb_periph_mux.sv
// Self-checking bench for wb_periph_mux with a transaction-level reference
// model.  Honours WB_PERIPH_MUX_TIMEOUT_EN the same way the design does.
module tb_wb_periph_mux;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NSLV    = 4;
  localparam int SEL_LSB = 8;
  localparam int IDX_W   = 2;
  localparam int BASE    = 0;
  localparam int TIMEOUT = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [ADDR_W-1:0]      sAddr;
  logic [DATA_W-1:0]      sWdata;
  logic                   sWe;
  logic [3:0]             sBe;
  logic                   sStb;
  logic                   sCyc;
  logic                   sAck;
  logic                   sErr;
  logic [DATA_W-1:0]      sRdata;
  logic [ADDR_W-1:0]      mAddr;
  logic [DATA_W-1:0]      mWdata;
  logic                   mWe;
  logic [3:0]             mBe;
  logic [NSLV-1:0]        mStb;
  logic [NSLV-1:0]        mCyc;
  logic [NSLV-1:0]        mAck;
  logic [NSLV*DATA_W-1:0] mRdata;

  int assertCount = 0;
  int failCount   = 0;
  bit pendingIdle = 0;
  logic [31:0] lastRdata = 32'h0;

  wb_periph_mux #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NSLV     (NSLV),
    .SEL_LSB  (SEL_LSB),
    .BASE     (32'(BASE)),
    .TIMEOUT  (TIMEOUT),
    .ERR_DATA (ERRD)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wbs_addr_i    (sAddr),
    .wbs_wdata_i   (sWdata),
    .wbs_wr_en_i   (sWe),
    .wbs_byte_en_i (sBe),
    .wbs_stb_i     (sStb),
    .wbs_cyc_i     (sCyc),
    .wbs_ack_o     (sAck),
    .wbs_err_o     (sErr),
    .wbs_rdata_o   (sRdata),
    .wbm_addr_o    (mAddr),
    .wbm_wdata_o   (mWdata),
    .wbm_wr_en_o   (mWe),
    .wbm_byte_en_o (mBe),
    .wbm_stb_o     (mStb),
    .wbm_cyc_o     (mCyc),
    .wbm_ack_i     (mAck),
    .wbm_rdata_i   (mRdata)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Hard time limit so a broken design can never stall the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Random bus noise on every slave read-data lane.
  task automatic scrambleSlaves();
    for (int i = 0; i < NSLV; i++) mRdata[i*DATA_W +: DATA_W] = $urandom;
  endtask

  // One complete upstream transfer: drives the request, plays the addressed
  // slave (acking after waitCycles wait states), and checks every cycle
  // against what the address decode and timeout rules predict.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic we, input logic [3:0] be,
                               input int waitCycles, input logic [31:0] slvData,
                               input bit stray);
    int  idx;
    bit  hit;
    bit  timedOut;
    int  accessCycles;
    bit  expErr;
    logic [31:0] expData;
    logic [3:0]  sel;

    idx = int'((addr >> SEL_LSB) % NSLV);
    hit = ((addr >> (SEL_LSB + IDX_W)) == BASE);
`ifdef WB_PERIPH_MUX_TIMEOUT_EN
    timedOut = hit && (waitCycles >= TIMEOUT);
`else
    timedOut = 1'b0;
`endif
    accessCycles = timedOut ? TIMEOUT : waitCycles + 1;
    expErr  = !hit || timedOut;
    expData = expErr ? ERRD : slvData;
    sel     = 4'(1 << idx);

    sAddr = addr; sWdata = wdata; sWe = we; sBe = be; sCyc = 1'b1; sStb = 1'b1;

    if (pendingIdle) begin
      @(negedge clk);
      checkOutput("idle_ack", sAck, 0);
      checkOutput("idle_stb", mStb, 0);
      checkOutput("idle_rdata_hold", sRdata, lastRdata);
    end

    if (hit) begin
      for (int c = 1; c <= accessCycles; c++) begin
        @(negedge clk);
        checkOutput("acc_stb", mStb, sel);
        checkOutput("acc_cyc", mCyc, sel);
        checkOutput("acc_ack", sAck, 0);
        if (c == 1) begin
          checkOutput("acc_addr", mAddr, addr);
          checkOutput("acc_wdata", mWdata, wdata);
          checkOutput("acc_we", mWe, we);
          checkOutput("acc_be", mBe, be);
        end
        scrambleSlaves();
        mAck = stray ? 4'(1 << ((idx + 1) % NSLV)) : 4'h0;
        if (c == waitCycles + 1) begin
          mAck[idx] = 1'b1;
          mRdata[idx*DATA_W +: DATA_W] = slvData;
        end
      end
    end

    @(negedge clk);
    checkOutput("resp_ack", sAck, 1);
    checkOutput("resp_err", sErr, expErr);
    checkOutput("resp_rdata", sRdata, expData);
    checkOutput("resp_stb", mStb, 0);
    checkOutput("resp_cyc", mCyc, 0);
    checkOutput("resp_we", mWe, 0);
    checkOutput("resp_be", mBe, 0);
    if (!hit) checkOutput("resp_addr", mAddr, addr);

    mAck = 4'h0; sCyc = 1'b0; sStb = 1'b0; sWe = 1'b0;
    lastRdata   = expData;
    pendingIdle = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    int          w;

    $display("[TB] start");
    rst = 1'b1; sAddr = '0; sWdata = '0; sWe = 1'b0; sBe = '0; sStb = 1'b0; sCyc = 1'b0;
    mAck = '0; mRdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ack", sAck, 0);
    checkOutput("rst_err", sErr, 0);
    checkOutput("rst_rdata", sRdata, 0);
    checkOutput("rst_stb", mStb, 0);
    checkOutput("rst_cyc", mCyc, 0);
    checkOutput("rst_addr", mAddr, 0);
    checkOutput("rst_we", mWe, 0);
    checkOutput("rst_be", mBe, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed: read slave 2 with three wait states.
    applyStimulus(32'h0000_0200, 32'h0, 1'b0, 4'hF, 3, 32'hA5A5_0002, 1'b0);
    // Directed: zero-wait write to slave 1.
    applyStimulus(32'h0000_0100, 32'h1234_5678, 1'b1, 4'b0011, 0, 32'h0BAD_F00D, 1'b0);
    // Directed: decode miss.
    applyStimulus(32'h0001_0000, 32'h0, 1'b0, 4'hF, 0, 32'h0, 1'b0);

`ifdef WB_PERIPH_MUX_TIMEOUT_EN
    // Slave 3 never acks, then acks in the last allowed cycle.
    applyStimulus(32'h0000_0300, 32'h0, 1'b0, 4'hF, 1000, 32'h0, 1'b0);
    applyStimulus(32'h0000_0300, 32'h0, 1'b0, 4'hF, TIMEOUT - 1, 32'h3333_0003, 1'b0);
`else
    // Without the watchdog a slow slave is simply waited for.
    applyStimulus(32'h0000_0300, 32'h0, 1'b0, 4'hF, 20, 32'h3333_0003, 1'b0);
`endif

    // Stray ack from slave 0 during an access to slave 1, then reset mid-access.
    sAddr = 32'h0000_0104; sWdata = 32'h0; sWe = 1'b1; sBe = 4'hF; sCyc = 1'b1; sStb = 1'b1;
    @(negedge clk);
    checkOutput("sr_idle_ack", sAck, 0);
    @(negedge clk);
    checkOutput("sr_stb1", mStb, 4'b0010);
    mAck = 4'b0001; mRdata[0 +: DATA_W] = 32'hBADD_0000;
    @(negedge clk);
    checkOutput("sr_stb2", mStb, 4'b0010);
    checkOutput("sr_stray_ack", sAck, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("sr_rst_ack", sAck, 0);
    checkOutput("sr_rst_stb", mStb, 0);
    checkOutput("sr_rst_cyc", mCyc, 0);
    checkOutput("sr_rst_rdata", sRdata, 0);
    checkOutput("sr_rst_addr", mAddr, 0);
    checkOutput("sr_rst_we", mWe, 0);
    rst = 1'b0; mAck = 4'h0; sCyc = 1'b0; sStb = 1'b0; sWe = 1'b0;
    @(negedge clk);
    checkOutput("sr_post_ack", sAck, 0);
    lastRdata = 32'h0; pendingIdle = 1'b0;

    // Back-to-back reads to slaves 0, 1, 3.
    applyStimulus(32'h0000_0010, 32'h0, 1'b0, 4'hF, 0, 32'h1111_0000, 1'b0);
    applyStimulus(32'h0000_0120, 32'h0, 1'b0, 4'hF, 0, 32'h1111_0001, 1'b0);
    applyStimulus(32'h0000_03F0, 32'h0, 1'b0, 4'hF, 0, 32'h1111_0003, 1'b0);

    // Master abort: cyc drops during ACCESS, no ack, rdata holds.
    sAddr = 32'h0000_0200; sWe = 1'b0; sBe = 4'hF; sCyc = 1'b1; sStb = 1'b1;
    @(negedge clk);
    checkOutput("ab_idle_ack", sAck, 0);
    @(negedge clk);
    checkOutput("ab_stb", mStb, 4'b0100);
    @(negedge clk);
    sCyc = 1'b0; sStb = 1'b0;
    @(negedge clk);
    checkOutput("ab_stb_drop", mStb, 0);
    checkOutput("ab_ack", sAck, 0);
    @(negedge clk);
    checkOutput("ab_ack2", sAck, 0);
    checkOutput("ab_rdata_hold", sRdata, lastRdata);
    pendingIdle = 1'b0;

    // Randomised transfers: mostly hits with random wait states, some misses.
    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      if ($urandom_range(4) != 0) begin
        a[31:SEL_LSB+IDX_W] = '0;
      end else if (a[31:SEL_LSB+IDX_W] == '0) begin
        a[20] = 1'b1;
      end
      w = int'($urandom_range(5));
      applyStimulus(a, $urandom, 1'($urandom), 4'($urandom), w, $urandom, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
